// File: rtl/multichannel_fan_ctrl.sv
// Multi-channel fan controller: shared incremental PI datapath + per-fan PWM.
// Optional FANCTRL_ANTIWINDUP_EN clamps the integrator to the actuator range.
module multichannel_fan_ctrl #(
  parameter int CHANNELS      = 4,
  parameter int ADC_BITWIDTH  = 8,
  parameter int COEF_BITWIDTH = 12,
  parameter int FRAC_BITWIDTH = 6,
  parameter int PWM_BITWIDTH  = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             sample_en_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0] adc_value_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0] set_value_i,
  input  logic [COEF_BITWIDTH-1:0]         b2_i,
  input  logic [COEF_BITWIDTH-1:0]         b0_i,
  input  logic [PWM_BITWIDTH-1:0]          pwm_period_i,
  input  logic [PWM_BITWIDTH-1:0]          pwm_min_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic [CHANNELS*PWM_BITWIDTH-1:0] duty_o,
  output logic [CHANNELS-1:0]              pwm_o
);

  localparam int E_W    = ADC_BITWIDTH + 1;
  localparam int ACC_W  = PWM_BITWIDTH + FRAC_BITWIDTH + 2;
  localparam int PROD_W = COEF_BITWIDTH + E_W;
  localparam int SUM_W  = ((PROD_W > ACC_W) ? PROD_W : ACC_W) + 2;
  localparam int D_W    = ACC_W - FRAC_BITWIDTH;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic signed [ACC_W-1:0] A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_ERR, S_MULA, S_MULB, S_WB, S_DONE
  } state_t;

  state_t                           r_state;
  logic [CH_W-1:0]                  r_ch;
  logic signed [E_W-1:0]            r_e;
  logic signed [PROD_W-1:0]         r_pa;
  logic signed [PROD_W-1:0]         r_pb;
  logic signed [ACC_W-1:0]          r_acc   [CHANNELS];
  logic signed [E_W-1:0]            r_eprev [CHANNELS];
  logic [CHANNELS*PWM_BITWIDTH-1:0] r_duty;
  logic                             r_busy;
  logic                             r_done;

  logic [PWM_BITWIDTH-1:0]          r_cnt;
  logic [CHANNELS*PWM_BITWIDTH-1:0] r_dact;
  logic [CHANNELS-1:0]              r_pwm;

  logic [ADC_BITWIDTH-1:0]   w_adc;
  logic [ADC_BITWIDTH-1:0]   w_set;
  logic signed [E_W-1:0]     w_e;
  logic signed [COEF_BITWIDTH-1:0] w_b2;
  logic signed [COEF_BITWIDTH-1:0] w_b0;
  logic signed [SUM_W-1:0]   w_sum;
  logic signed [ACC_W-1:0]   w_sat;
  logic signed [ACC_W-1:0]   w_acc_new;
  logic signed [D_W-1:0]     w_q;
  logic signed [D_W-1:0]     w_per;
  logic [PWM_BITWIDTH-1:0]   w_clamp;
  logic [PWM_BITWIDTH-1:0]   w_duty;
  logic                      w_last;

  assign w_b2 = b2_i;
  assign w_b0 = b0_i;
  assign w_last = (r_ch == CH_W'(CHANNELS - 1));

  // Error, accumulator update, saturation and duty shaping for channel r_ch
  always_comb begin
    w_adc = adc_value_i[int'(r_ch)*ADC_BITWIDTH +: ADC_BITWIDTH];
    w_set = set_value_i[int'(r_ch)*ADC_BITWIDTH +: ADC_BITWIDTH];
    w_e   = $signed({1'b0, w_adc}) - $signed({1'b0, w_set});
    w_sum = SUM_W'(r_acc[r_ch]) + SUM_W'(r_pa) + SUM_W'(r_pb);
    if (w_sum > SUM_W'(A_MAX)) begin
      w_sat = A_MAX;
    end else if (w_sum < SUM_W'(A_MIN)) begin
      w_sat = A_MIN;
    end else begin
      w_sat = w_sum[ACC_W-1:0];
    end
    w_acc_new = w_sat;
`ifdef FANCTRL_ANTIWINDUP_EN
    if (w_sat < 0) begin
      w_acc_new = '0;
    end else if (w_sat > $signed({2'b00, pwm_period_i,
                                  {FRAC_BITWIDTH{1'b0}}})) begin
      w_acc_new = $signed({2'b00, pwm_period_i, {FRAC_BITWIDTH{1'b0}}});
    end
`endif
    w_q   = w_acc_new[ACC_W-1:FRAC_BITWIDTH];
    w_per = $signed({2'b00, pwm_period_i});
    if (w_q < 0) begin
      w_clamp = '0;
    end else if (w_q > w_per) begin
      w_clamp = pwm_period_i;
    end else begin
      w_clamp = w_q[PWM_BITWIDTH-1:0];
    end
    w_duty = w_clamp;
    if (w_clamp != '0 && w_clamp < pwm_min_i) begin
      w_duty = (pwm_min_i > pwm_period_i) ? pwm_period_i : pwm_min_i;
    end
  end

  // Sequencer: walks every channel through ERR/MULA/MULB/WB per strobe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_e     <= '0;
      r_pa    <= '0;
      r_pb    <= '0;
      r_duty  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_acc[c]   <= '0;
        r_eprev[c] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (sample_en_i) begin
            r_state <= S_ERR;
            r_ch    <= '0;
            r_busy  <= 1'b1;
          end
        end
        S_ERR: begin
          r_e     <= w_e;
          r_state <= S_MULA;
        end
        S_MULA: begin
          r_pa    <= PROD_W'(w_b2) * PROD_W'(r_e);
          r_state <= S_MULB;
        end
        S_MULB: begin
          r_pb    <= PROD_W'(w_b0) * PROD_W'(r_eprev[r_ch]);
          r_state <= S_WB;
        end
        S_WB: begin
          r_acc[r_ch]   <= w_acc_new;
          r_eprev[r_ch] <= r_e;
          r_duty[int'(r_ch)*PWM_BITWIDTH +: PWM_BITWIDTH] <= w_duty;
          if (w_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_ch    <= r_ch + CH_W'(1);
            r_state <= S_ERR;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Shared PWM counter; duties are reloaded only at the wrap
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt  <= '0;
      r_dact <= '0;
      r_pwm  <= '0;
    end else if (pwm_period_i == '0) begin
      r_cnt <= '0;
      r_pwm <= '0;
    end else begin
      if (r_cnt >= pwm_period_i - PWM_BITWIDTH'(1)) begin
        r_cnt  <= '0;
        r_dact <= r_duty;
      end else begin
        r_cnt <= r_cnt + PWM_BITWIDTH'(1);
      end
      for (int c = 0; c < CHANNELS; c++) begin
        r_pwm[c] <= (r_cnt < r_dact[c*PWM_BITWIDTH +: PWM_BITWIDTH]);
      end
    end
  end

  assign busy_o = r_busy;
  assign done_o = r_done;
  assign duty_o = r_duty;
  assign pwm_o  = r_pwm;

endmodule

// File: tb/tb_multichannel_fan_ctrl.sv
// Scoreboard bench for multichannel_fan_ctrl (4 channels, default widths).
module tb_multichannel_fan_ctrl;
  localparam int CH = 4;
  localparam int AW = 8;
  localparam int CW = 12;
  localparam int PW = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic               sample_en;
  logic [CH*AW-1:0]   adc;
  logic [CH*AW-1:0]   setv;
  logic [CW-1:0]      b2;
  logic [CW-1:0]      b0;
  logic [PW-1:0]      period;
  logic [PW-1:0]      pmin;
  logic               busy;
  logic               done;
  logic [CH*PW-1:0]   duty;
  logic [CH-1:0]      pwm;

  int total = 0;
  int bad   = 0;
  logic [CH*PW-1:0] exp_q[$];

  multichannel_fan_ctrl dut (
    .clk_i(clk), .rst_i(rst), .sample_en_i(sample_en),
    .adc_value_i(adc), .set_value_i(setv),
    .b2_i(b2), .b0_i(b0),
    .pwm_period_i(period), .pwm_min_i(pmin),
    .busy_o(busy), .done_o(done),
    .duty_o(duty), .pwm_o(pwm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, req);
    end
  endtask

  // monitor: pops one expected duty vector per done pulse
  always @(negedge clk) begin : mon
    logic [CH*PW-1:0] ev;
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        ev = exp_q.pop_front();
        for (int c = 0; c < CH; c++)
          chk($sformatf("duty_ch%0d", c),
              int'(duty[c*PW +: PW]), int'(ev[c*PW +: PW]));
      end
    end
  end

  task automatic set_ch(input int c, input int a, input int s);
    adc[c*AW +: AW]  = AW'(a);
    setv[c*AW +: AW] = AW'(s);
  endtask

  task automatic do_update(input logic [CH*PW-1:0] ex, input bit lat_chk);
    int lat;
    int nd;
    exp_q.push_back(ex);
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    lat = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (lat_chk && j == 1) chk("busy_after_strobe", int'(busy), 1);
      if (lat_chk && j == 4) sample_en = 1'b1;
      if (lat_chk && j == 5) sample_en = 1'b0;
      if (done) begin
        lat = j;
        break;
      end
    end
    if (lat == 0) chk("done_timeout", 0, 1);
    else if (lat_chk) chk("done_latency", lat, 16);
    @(negedge clk);
    chk("done_pulse_width", int'(done), 0);
    chk("busy_clear", int'(busy), 0);
    if (lat_chk) begin
      nd = 0;
      repeat (30) begin
        @(negedge clk);
        if (done || busy) nd++;
      end
      chk("ignored_strobe", nd, 0);
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int nlow;
    int h1;
    int h2;
    bit prev;
    bit found;
    rst       = 1'b1;
    sample_en = 1'b0;
    adc       = '0;
    setv      = '0;
    b2        = CW'(64);
    b0        = CW'(-64);
    period    = PW'(100);
    pmin      = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_duty", int'(duty), 0);
    chk("rst_pwm", int'(pwm), 0);
    rst = 1'b0;
    @(negedge clk);

    // proportional step on ch0, others balanced
    set_ch(0, 20, 10);
    set_ch(1, 50, 50);
    set_ch(2, 50, 50);
    set_ch(3, 50, 50);
    do_update({8'd0, 8'd0, 8'd0, 8'd10}, 1'b1);
    do_update({8'd0, 8'd0, 8'd0, 8'd10}, 1'b0);

    // minimum speed floor: 10->30, 5->30, 0->0, 40->40
    pmin = PW'(30);
    set_ch(1, 55, 50);
    set_ch(3, 90, 50);
    do_update({8'd40, 8'd0, 8'd30, 8'd30}, 1'b0);

    // reset in the middle of an update
    sample_en = 1'b1;
    @(negedge clk);
    sample_en = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_duty", int'(duty), 0);
    chk("midrst_pwm", int'(pwm), 0);
    rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("midrst_idle", int'(busy), 0);
    pmin = '0;
    set_ch(1, 50, 50);
    do_update({8'd40, 8'd0, 8'd0, 8'd10}, 1'b0);

    // saturation / windup with an integral term
    reset_dut();
    b2 = CW'(128);
    set_ch(0, 150, 50);
    set_ch(3, 50, 50);
    repeat (5) do_update({8'd0, 8'd0, 8'd0, 8'd100}, 1'b0);
    repeat (110) @(negedge clk);
    nlow = 0;
    repeat (200) begin
      @(negedge clk);
      if (!pwm[0]) nlow++;
    end
    chk("pwm_const_high", nlow, 0);
    set_ch(0, 40, 50);
`ifdef FANCTRL_ANTIWINDUP_EN
    do_update({8'd0, 8'd0, 8'd0, 8'd0}, 1'b0);
`else
    do_update({8'd0, 8'd0, 8'd0, 8'd100}, 1'b0);
`endif

    // glitch-free duty change in the middle of a period
    reset_dut();
    b2 = CW'(64);
    set_ch(0, 80, 50);
    do_update({8'd0, 8'd0, 8'd0, 8'd30}, 1'b0);
    repeat (120) @(negedge clk);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      prev = pwm[0];
      @(negedge clk);
      if (!prev && pwm[0]) begin
        found = 1'b1;
        break;
      end
    end
    chk("pwm_rise_found", int'(found), 1);
    fork
      begin
        h1 = int'(pwm[0]);
        repeat (99) begin
          @(negedge clk);
          h1 += int'(pwm[0]);
        end
        h2 = 0;
        repeat (100) begin
          @(negedge clk);
          h2 += int'(pwm[0]);
        end
      end
      begin
        repeat (40) @(negedge clk);
        set_ch(0, 120, 50);
        do_update({8'd0, 8'd0, 8'd0, 8'd70}, 1'b0);
      end
    join
    chk("period_old_high", h1, 30);
    chk("period_new_high", h2, 70);

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multichannel_fan_ctrl.md
# multichannel_fan_ctrl

Parametrised multi-channel successor of the single-channel fan controller. One shared, time-multiplexed incremental PI datapath updates CHANNELS independent fan loops on each sample strobe. Each loop drives its own glitch-free PWM output with a minimum-speed floor. The block sits between the per-fan ADC/setpoint registers and the fan driver pins.

## Interface
- CHANNELS, 4: number of fan loops, ≥1
- ADC_BITWIDTH, 8: unsigned width of ADC and setpoint values
- COEF_BITWIDTH, 12: signed coefficient width
- FRAC_BITWIDTH, 6: fractional bits of coefficients and accumulator
- PWM_BITWIDTH, 8: width of PWM period, duty and minimum
- Derived ACC_W = PWM_BITWIDTH+FRAC_BITWIDTH+2, signed per-channel accumulator

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- sample_en_i  in  1  one-cycle strobe that starts an update of all channels
- adc_value_i  in  CHANNELS*ADC_BITWIDTH  measured values; channel c at [c*ADC_BITWIDTH +: ADC_BITWIDTH]
- set_value_i  in  CHANNELS*ADC_BITWIDTH  setpoints, same packing
- b2_i  in  COEF_BITWIDTH  signed coefficient on e[k]
- b0_i  in  COEF_BITWIDTH  signed coefficient on e[k-1]
- pwm_period_i  in  PWM_BITWIDTH  PWM period in clocks
- pwm_min_i  in  PWM_BITWIDTH  minimum non-zero duty
- busy_o  out  1  update in progress
- done_o  out  1  one-cycle pulse when all channels have been updated
- duty_o  out  CHANNELS*PWM_BITWIDTH  latest computed duty per channel
- pwm_o  out  CHANNELS  registered PWM outputs

## Operation
- Per channel: e[k] = adc − set, signed ADC_BITWIDTH+1 bits. acc[k] = acc[k-1] + b2·e[k] + b0·e[k-1]. Sum is formed at full width, then saturated to the signed ACC_W range. e[k] is stored as e[k-1].
- Duty = acc >>> FRAC_BITWIDTH (floor), clamped to [0, pwm_period_i]. A clamped duty in 1..pwm_min_i−1 becomes pwm_min_i, itself capped at pwm_period_i. A duty of 0 stays 0 (fan off).
- FSM states: IDLE, ERR, MULA, MULB, WB, DONE. Channel index ch runs 0..CHANNELS−1.
  - IDLE: sample_en_i=1 → ERR with ch=0.
  - ERR: latch channel ch adc/set, compute e.
  - MULA: compute b2·e.
  - MULB: compute b0·e_prev.
  - WB: write acc, e_prev and duty_o[ch]. Go to ERR with ch+1, or to DONE after the last channel.
  - DONE: → IDLE.
- Inputs are sampled in the state named, not snapshotted at the strobe. Coefficients must be held stable while busy_o=1.
- sample_en_i is ignored in every state except IDLE.
- PWM: one shared counter cnt runs 0..pwm_period_i−1, then wraps.
  - At the wrap, every duty_active[c] loads from duty_o[c], so there are no mid-period glitches.
  - pwm_o[c] is registered (cnt < duty_active[c]). duty = period gives a constant high output.
  - pwm_period_i = 0: cnt is held at 0 and all pwm_o are low.
  - pwm_period_i changed mid-period: if cnt ≥ new period, the counter wraps on the next cycle.
- Reset: FSM to IDLE, ch, cnt, acc, e_prev, duty_o, duty_active all 0. pwm_o, busy_o, done_o are 0. Reset mid-update discards the partial update.

## Timing
- Strobe sampled at edge k. busy_o is high from cycle k+1 until DONE exits.
- Channel c writes back at edge k+4c+4.
- done_o is high for exactly the cycle after edge k+4·CHANNELS. busy_o is also high in DONE.
- The earliest accepted next strobe is at edge k+4·CHANNELS+2.
- A new duty reaches pwm_o one cycle after the next counter wrap.

## Configuration
- FANCTRL_ANTIWINDUP_EN defined:
  - After WB saturation, acc is additionally clamped to [0, pwm_period_i<<FRAC_BITWIDTH].
  - The integrator cannot wind beyond the actuator range.
- Not defined:
  - acc saturates only at the ACC_W limits.
  - Duty clamping is applied to the output only.

## Test plan
- Reset: rst_i high 3 cycles mid-update → pwm_o=0, duty_o=0, busy_o=0, done_o=0, FSM IDLE. The next strobe completes normally.
- Latency with CHANNELS=4: strobe at edge k → done_o single pulse after edge k+16. A strobe at k+5 is ignored.
- Proportional step (FRAC=6, b2=64, b0=−64, period=100, min=0): ch0 adc=20, set=10.
  - First update → duty_o[0]=10.
  - Second update with the same inputs → still 10.
  - Other channels at e=0 stay 0.
- Min speed with pwm_min=30:
  - Computed duty 5 → 30.
  - Computed 0 → 0.
  - Computed 40 → 40.
- Saturation/windup, period=100: e=+100 held for 5 updates, then e=−10.
  - With FANCTRL_ANTIWINDUP_EN, duty drops below 100 on the first negative update.
  - Without it, duty stays 100.
  - pwm_o is constantly high at duty 100.
- Glitch-free update: duty changed 30→70 at cnt=50.
  - The current period keeps 30 high cycles.
  - The next period shows 70 high cycles.
